// File: rtl/mic_pkg.sv
// Shared constants and state type for the microphone frame buffer; the correlator
// imports the same constants so both sides agree on frame geometry.
package mic_pkg;

    localparam int MIC_DATA_W   = 18;
    localparam int MIC_DEPTH    = 1024;
    localparam int MIC_ADDR_W   = $clog2(MIC_DEPTH);
    localparam int MIC_DC_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2,
        LOCKED  = 2'd3
    } mic_state_e;

    // A stored frame is only trustworthy once every slot has been written.
    function automatic logic frame_held(input mic_state_e s);
        return (s == FULL) || (s == LOCKED);
    endfunction

endpackage

// File: rtl/mic_frame_ram.sv
// DEPTH x DATA_W frame store: one write port, one registered read port with
// read-before-write behaviour so it maps onto a simple dual-port block RAM.
module mic_frame_ram
    import mic_pkg::*;
#(
    parameter int DATA_W = MIC_DATA_W,
    parameter int DEPTH  = MIC_DEPTH,
    parameter int ADDR_W = MIC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself is deliberately not reset so it stays a block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mic_frame_buffer.sv
// Single-microphone frame buffer serving the correlator's locked random-access reads.
// Optional DC-blocking of stored samples is enabled with MIC_BUF_DC_BLOCK_EN.
//
// state   | meaning
// IDLE    | no frame held, waiting for start
// CAPTURE | writing incoming samples at wr_ptr
// FULL    | complete frame held, frame_ready high, waiting for reader lock
// LOCKED  | reader owns the frame, contents frozen until rd_lock drops
module mic_frame_buffer
    import mic_pkg::*;
#(
    parameter int DATA_W = MIC_DATA_W,
    parameter int DEPTH  = MIC_DEPTH,
    parameter int ADDR_W = MIC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              rd_lock,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              capturing,
    output logic              overrun
);

    mic_state_e        state;
    mic_state_e        state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              start_accept;
    logic              last_write;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (last_write) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // Lock wins over a simultaneous restart: the reader already committed.
                if (rd_lock) begin
                    state_next = LOCKED;
                end else if (start) begin
                    state_next = CAPTURE;
                end
            end
            LOCKED: begin
                if (!rd_lock) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capturing    = (state == CAPTURE);
        frame_ready  = (state == FULL);
        wr_en        = (state == CAPTURE) && sample_valid;
        last_write   = wr_en && (wr_ptr == ADDR_W'(DEPTH - 1));
        start_accept = start && ((state == IDLE) || ((state == FULL) && !rd_lock));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (start_accept) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (start_accept) begin
            overrun <= 1'b0;
        end else if (sample_valid && frame_held(state)) begin
            overrun <= 1'b1;
        end
    end

`ifdef MIC_BUF_DC_BLOCK_EN
    // avg_acc holds the running mean with MIC_DC_SHIFT fractional bits, so the
    // residual keeps decaying below one LSB instead of stalling at 2^shift.
    localparam int ACC_W = DATA_W + MIC_DC_SHIFT;

    logic signed [ACC_W-1:0]  avg_acc;
    logic signed [DATA_W-1:0] avg_int;
    logic signed [DATA_W:0]   diff;
    logic signed [ACC_W:0]    err;
    logic signed [ACC_W-1:0]  step;

    assign avg_int = avg_acc[ACC_W-1:MIC_DC_SHIFT];
    assign diff    = {sample_in[DATA_W-1], sample_in} - {avg_int[DATA_W-1], avg_int};
    assign err     = {sample_in[DATA_W-1], sample_in, {MIC_DC_SHIFT{1'b0}}}
                   - {avg_acc[ACC_W-1], avg_acc};
    assign step    = ACC_W'(err >>> MIC_DC_SHIFT);

    always_comb begin
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            wr_data = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            wr_data = diff[DATA_W-1:0];
        end
    end

    // Mean carries across frames; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_acc <= '0;
        end else if (wr_en) begin
            avg_acc <= avg_acc + step;
        end
    end
`else
    assign wr_data = sample_in;
`endif

    mic_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Bench for mic_frame_buffer: a frame-level behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mic_frame_buffer;

    localparam int DATA_W = 18;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              rd_lock = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              frame_ready;
    logic              capturing;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mic_frame_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .rd_lock      (rd_lock),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .capturing    (capturing),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_mem [DEPTH];
    bit  m_known [DEPTH];
    bit  m_cap = 1'b0, m_ready = 1'b0, m_locked = 1'b0, m_ovr = 1'b0;
    int  m_count = 0;
    int  m_rd = 0;
    bit  m_rd_chk = 1'b1;
    int  dc_acc = 0;

    function automatic int store_val(input int x);
`ifdef MIC_BUF_DC_BLOCK_EN
        int d;
        d = x - (dc_acc >>> 6);
        if (d > 131071)  d = 131071;
        if (d < -131072) d = -131072;
        dc_acc = dc_acc + ((x * 64 - dc_acc) >>> 6);
        return d;
`else
        return x;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        int x;
        if (rst) begin
            m_cap = 0; m_ready = 0; m_locked = 0; m_ovr = 0; m_count = 0;
            m_rd = 0; m_rd_chk = 1; dc_acc = 0;
        end else begin
            x = int'($signed(sample_in));
            m_rd_chk = m_known[rd_addr];
            m_rd = m_mem[rd_addr];
            if (m_locked) begin
                if (sample_valid) m_ovr = 1;
                if (!rd_lock) m_locked = 0;
            end else if (m_ready) begin
                if (sample_valid) m_ovr = 1;
                if (rd_lock) begin
                    m_ready = 0; m_locked = 1;
                end else if (start) begin
                    m_ready = 0; m_cap = 1; m_count = 0; m_ovr = 0;
                end
            end else if (m_cap) begin
                if (sample_valid) begin
                    m_mem[m_count] = store_val(x);
                    m_known[m_count] = 1;
                    m_count++;
                    if (m_count == DEPTH) begin
                        m_cap = 0; m_ready = 1;
                    end
                end
            end else if (start) begin
                m_cap = 1; m_count = 0; m_ovr = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_frame_ready", int'(frame_ready), int'(m_ready));
            chk("model_capturing", int'(capturing), int'(m_cap));
            chk("model_overrun", int'(overrun), int'(m_ovr));
            if (m_rd_chk) chk("model_rd_data", int'($signed(rd_data)), m_rd);
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic sv, input int x, input logic lk, input int ra);
        #1;
        start        = s;
        sample_valid = sv;
        sample_in    = DATA_W'(x);
        rd_lock      = lk;
        rd_addr      = ADDR_W'(ra);
        @(negedge clk);
    endtask

    function automatic int first_sample(input int i);
`ifdef MIC_BUF_DC_BLOCK_EN
        return 1000;
`else
        return i;
`endif
    endfunction

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_frame_ready", int'(frame_ready), 0);
        chk("reset_capturing", int'(capturing), 0);
        chk("reset_overrun", int'(overrun), 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Frame 1, with an ignored start at sample 100.
        cyc(1, 0, 0, 0, 0);
        chk("start_capturing", int'(capturing), 1);
        for (int i = 0; i < DEPTH; i++) cyc(i == 100, 1, first_sample(i), 0, 0);
        chk("ready_after_last", int'(frame_ready), 1);
        chk("capturing_drops", int'(capturing), 0);
`ifdef MIC_BUF_DC_BLOCK_EN
        cyc(0, 0, 0, 0, 0);
        chk("dc_addr0", int'($signed(rd_data)), 1000);
        cyc(0, 0, 0, 0, 1);
        chk("dc_addr1", int'($signed(rd_data)), 985);
        cyc(0, 0, 0, 0, 1023);
        chk("dc_addr1023_small", int'(($signed(rd_data) < 10) && ($signed(rd_data) >= 0)), 1);
`else
        cyc(0, 0, 0, 0, 0);
        chk("read_addr0", int'($signed(rd_data)), 0);
        cyc(0, 0, 0, 0, 511);
        chk("read_addr511", int'($signed(rd_data)), 511);
        cyc(0, 0, 0, 0, 1023);
        chk("read_addr1023", int'($signed(rd_data)), 1023);
        cyc(0, 0, 0, 0, 100);
        chk("read_addr100", int'($signed(rd_data)), 100);
`endif

        // Lock, then samples arriving while locked must be dropped.
        cyc(0, 0, 0, 1, 0);
        chk("lock_drops_ready", int'(frame_ready), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, -7, 1, i);
`ifndef MIC_BUF_DC_BLOCK_EN
            chk("locked_addr_unchanged", int'($signed(rd_data)), i);
`endif
        end
        chk("overrun_when_locked", int'(overrun), 1);
        cyc(1, 0, 0, 1, 0);
        chk("start_ignored_locked", int'(capturing), 0);
        cyc(1, 0, 0, 0, 0);
        chk("start_ignored_on_unlock", int'(capturing), 0);

        // Start with a coincident sample in IDLE: that sample must not be stored.
        cyc(1, 1, 12345, 0, 0);
        chk("idle_start_capturing", int'(capturing), 1);
        chk("idle_start_clears_overrun", int'(overrun), 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 3 * i - 1500, 0, (i * 37) % DEPTH);
`ifndef MIC_BUF_DC_BLOCK_EN
        cyc(0, 0, 0, 0, 0);
        chk("frame2_addr0", int'($signed(rd_data)), -1500);
        cyc(0, 0, 0, 0, 1023);
        chk("frame2_addr1023", int'($signed(rd_data)), 1569);
`endif

        // Restart from FULL discards the frame and clears overrun.
        cyc(0, 1, 99, 0, 0);
        chk("overrun_in_full", int'(overrun), 1);
        cyc(1, 0, 0, 0, 0);
        chk("restart_capturing", int'(capturing), 1);
        chk("restart_ready_low", int'(frame_ready), 0);
        chk("restart_overrun_clear", int'(overrun), 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 5000 + i, 0, i);

        // Reset mid-capture.
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midreset_rd_data", int'(rd_data), 0);
        chk("midreset_frame_ready", int'(frame_ready), 0);
        chk("midreset_capturing", int'(capturing), 0);
        chk("midreset_overrun", int'(overrun), 0);
        #1 rst = 1'b0;
        @(negedge clk);

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 7 * i, 0, i);
`ifndef MIC_BUF_DC_BLOCK_EN
        cyc(0, 0, 0, 0, 3);
        chk("recapture_addr3", int'($signed(rd_data)), 21);
        cyc(0, 0, 0, 0, 10);
        chk("stale_addr10", int'($signed(rd_data)), 5010);
`endif
        for (int i = 10; i < DEPTH; i++) cyc(0, 1, -100 * i, 0, (DEPTH - 1) - i);
        chk("frame3_ready", int'(frame_ready), 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, (i >= 2), (i * 61) % DEPTH);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("unlock_idle_ready", int'(frame_ready), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
